dmem_access_ctrl: RTL and testbench

- Sequences MEM-stage load/store instructions onto a single-port, variable-latency data memory.
- Stalls the pipeline until the memory acknowledges the access.
- Generates byte enables and replicated store lanes for sb/sh/sw.
- Right-aligns load data and forwards it with its opcode to the WB-stage load sign/zero-extension unit. Detects misaligned accesses and memory timeouts.

---
 rtl/dmem_access_ctrl.sv | 245 ++++++++++++++++++++++++
 tb/tb_dmem_access_ctrl.sv | 293 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/dmem_access_ctrl.sv
// dmem_access_ctrl
//   Sequences MEM-stage loads and stores onto a single-port data memory
//   whose latency varies. The pipeline is stalled until the memory
//   acknowledges the access or the timeout expires.
//
//   State table:
//     state | meaning
//     IDLE  | waiting for an aligned memory op; stall asserts in the accept cycle
//     BUSY  | access on the bus (mem_en high); waiting for mem_ack or timeout
//     RESP  | one cycle with stall low so the instruction leaves MEM; req ignored
//
//   Ports:
//     clk, reset            rising-edge clock, async active-high reset
//     req_*                 MEM-stage instruction (valid, opcode, byte addr, rt data)
//     stall, misalign       combinational pipeline controls
//     bus_err               one-cycle pulse when an access times out
//     mem_*                 memory request (en/we/be/addr/wdata) and response (rdata/ack)
//     ld_valid/opcode/data  right-aligned raw load result for the WB extension unit
module dmem_access_ctrl #(
    parameter int unsigned TIMEOUT_CYC = 255,
    parameter int unsigned CNT_W       = 16
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        req_valid,
    input  logic [5:0]  req_opcode,
    input  logic [31:0] req_addr,
    input  logic [31:0] req_wdata,
    output logic        stall,
    output logic        misalign,
    output logic        bus_err,
    output logic        mem_en,
    output logic        mem_we,
    output logic [3:0]  mem_be,
    output logic [31:0] mem_addr,
    output logic [31:0] mem_wdata,
    input  logic [31:0] mem_rdata,
    input  logic        mem_ack,
    output logic        ld_valid,
    output logic [5:0]  ld_opcode,
    output logic [31:0] ld_data
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        BUSY = 2'd1,
        RESP = 2'd2
    } state_t;

    localparam logic [1:0] SZ_B = 2'd0;
    localparam logic [1:0] SZ_H = 2'd1;
    localparam logic [1:0] SZ_W = 2'd2;

    localparam logic [CNT_W-1:0] TO_LAST = CNT_W'(TIMEOUT_CYC - 1);

    state_t state_q, state_d;

    logic [5:0]       op_q, op_d;
    logic [1:0]       a_q, a_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             mem_en_q, mem_en_d;
    logic             mem_we_q, mem_we_d;
    logic [3:0]       mem_be_q, mem_be_d;
    logic [31:0]      mem_addr_q, mem_addr_d;
    logic [31:0]      mem_wdata_q, mem_wdata_d;
    logic             ld_valid_q, ld_valid_d;
    logic [5:0]       ld_opcode_q, ld_opcode_d;
    logic [31:0]      ld_data_q, ld_data_d;
    logic             bus_err_q, bus_err_d;

    logic        is_load, is_store, is_mem, mis_c, accept, timeout_c;
    logic [1:0]  sz_c;
    logic [3:0]  be_c;
    logic [31:0] wdata_c;
    logic [31:0] ld_align;

    // Request decode
    always_comb begin
        is_load  = 1'b0;
        is_store = 1'b0;
        sz_c     = SZ_B;
        case (req_opcode)
            6'b100000, 6'b100100: begin is_load  = 1'b1; sz_c = SZ_B; end
            6'b100001, 6'b100101: begin is_load  = 1'b1; sz_c = SZ_H; end
            6'b100011, 6'b100111: begin is_load  = 1'b1; sz_c = SZ_W; end
            6'b101000:            begin is_store = 1'b1; sz_c = SZ_B; end
            6'b101001:            begin is_store = 1'b1; sz_c = SZ_H; end
            6'b101011:            begin is_store = 1'b1; sz_c = SZ_W; end
            default: ;
        endcase
    end

    assign is_mem = is_load | is_store;
    assign mis_c  = ((sz_c == SZ_H) && req_addr[0]) ||
                    ((sz_c == SZ_W) && (req_addr[1:0] != 2'b00));
    assign accept = (state_q == IDLE) && req_valid && is_mem && !mis_c;
    assign timeout_c = (cnt_q == TO_LAST);

    // Lane generation; loads share the byte enables but never drive data
    always_comb begin
        be_c    = 4'b1111;
        wdata_c = 32'h0;
        case (sz_c)
            SZ_B: begin
                be_c    = 4'b0001 << req_addr[1:0];
                wdata_c = {4{req_wdata[7:0]}};
            end
            SZ_H: begin
                be_c    = req_addr[1] ? 4'b1100 : 4'b0011;
                wdata_c = {2{req_wdata[15:0]}};
            end
            default: begin
                be_c    = 4'b1111;
                wdata_c = req_wdata;
            end
        endcase
        if (!is_store) begin
            wdata_c = 32'h0;
        end
    end

    // Load right-alignment; op_q[1:0] encodes size for every load opcode
    always_comb begin
        ld_align = mem_rdata;
        case (op_q[1:0])
            2'b00:   ld_align = {24'h0, mem_rdata[{a_q, 3'b000} +: 8]};
            2'b01:   ld_align = {16'h0, a_q[1] ? mem_rdata[31:16] : mem_rdata[15:0]};
            default: ld_align = mem_rdata;
        endcase
    end

    // State and datapath registers
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q     <= IDLE;
            op_q        <= 6'h0;
            a_q         <= 2'b00;
            cnt_q       <= '0;
            mem_en_q    <= 1'b0;
            mem_we_q    <= 1'b0;
            mem_be_q    <= 4'h0;
            mem_addr_q  <= 32'h0;
            mem_wdata_q <= 32'h0;
            ld_valid_q  <= 1'b0;
            ld_opcode_q <= 6'h0;
            ld_data_q   <= 32'h0;
            bus_err_q   <= 1'b0;
        end else begin
            state_q     <= state_d;
            op_q        <= op_d;
            a_q         <= a_d;
            cnt_q       <= cnt_d;
            mem_en_q    <= mem_en_d;
            mem_we_q    <= mem_we_d;
            mem_be_q    <= mem_be_d;
            mem_addr_q  <= mem_addr_d;
            mem_wdata_q <= mem_wdata_d;
            ld_valid_q  <= ld_valid_d;
            ld_opcode_q <= ld_opcode_d;
            ld_data_q   <= ld_data_d;
            bus_err_q   <= bus_err_d;
        end
    end

    // Next-state logic; an ack wins over a timeout in the same cycle
    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (accept) state_d = BUSY;
            BUSY:    if (mem_ack || timeout_c) state_d = RESP;
            RESP:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // Registered output and datapath next values
    always_comb begin
        op_d        = op_q;
        a_d         = a_q;
        cnt_d       = cnt_q;
        mem_en_d    = mem_en_q;
        mem_we_d    = mem_we_q;
        mem_be_d    = mem_be_q;
        mem_addr_d  = mem_addr_q;
        mem_wdata_d = mem_wdata_q;
        ld_valid_d  = 1'b0;
        ld_opcode_d = ld_opcode_q;
        ld_data_d   = ld_data_q;
        bus_err_d   = 1'b0;
        case (state_q)
            IDLE: begin
                if (accept) begin
                    op_d        = req_opcode;
                    a_d         = req_addr[1:0];
                    cnt_d       = '0;
                    mem_en_d    = 1'b1;
                    mem_we_d    = is_store;
                    mem_be_d    = be_c;
                    mem_addr_d  = {req_addr[31:2], 2'b00};
                    mem_wdata_d = wdata_c;
                end
            end
            BUSY: begin
                cnt_d = cnt_q + 1'b1;
                if (mem_ack) begin
                    mem_en_d = 1'b0;
                    // Loads are 100xxx, stores 101xxx
                    if (!op_q[3]) begin
                        ld_valid_d  = 1'b1;
                        ld_opcode_d = op_q;
                        ld_data_d   = ld_align;
                    end
                end else if (timeout_c) begin
                    mem_en_d  = 1'b0;
                    bus_err_d = 1'b1;
                end
            end
            RESP: begin
                cnt_d = '0;
            end
            default: ;
        endcase
    end

    // Combinational pipeline controls; forced low while reset is held
    always_comb begin
        stall    = 1'b0;
        misalign = 1'b0;
        if (!reset) begin
            stall    = accept || (state_q == BUSY);
            misalign = (state_q == IDLE) && req_valid && is_mem && mis_c;
        end
    end

    assign mem_en    = mem_en_q;
    assign mem_we    = mem_we_q;
    assign mem_be    = mem_be_q;
    assign mem_addr  = mem_addr_q;
    assign mem_wdata = mem_wdata_q;
    assign ld_valid  = ld_valid_q;
    assign ld_opcode = ld_opcode_q;
    assign ld_data   = ld_data_q;
    assign bus_err   = bus_err_q;

endmodule

// File: tb/tb_dmem_access_ctrl.sv
// tb_dmem_access_ctrl
//   Directed bench for dmem_access_ctrl. Stimulus pushes expected memory
//   accesses, load results and bus errors into queues; a monitor pops and
//   compares whenever the DUT presents one of those outputs.
module tb_dmem_access_ctrl;

    localparam int TO = 4;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        req_valid = 1'b0;
    logic [5:0]  req_opcode = 6'h0;
    logic [31:0] req_addr = 32'h0;
    logic [31:0] req_wdata = 32'h0;
    logic        stall, misalign, bus_err;
    logic        mem_en, mem_we;
    logic [3:0]  mem_be;
    logic [31:0] mem_addr, mem_wdata;
    logic [31:0] mem_rdata = 32'h0;
    logic        mem_ack = 1'b0;
    logic        ld_valid;
    logic [5:0]  ld_opcode;
    logic [31:0] ld_data;

    dmem_access_ctrl #(.TIMEOUT_CYC(TO), .CNT_W(16)) dut (
        .clk(clk), .reset(reset),
        .req_valid(req_valid), .req_opcode(req_opcode),
        .req_addr(req_addr), .req_wdata(req_wdata),
        .stall(stall), .misalign(misalign), .bus_err(bus_err),
        .mem_en(mem_en), .mem_we(mem_we), .mem_be(mem_be),
        .mem_addr(mem_addr), .mem_wdata(mem_wdata),
        .mem_rdata(mem_rdata), .mem_ack(mem_ack),
        .ld_valid(ld_valid), .ld_opcode(ld_opcode), .ld_data(ld_data)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [31:0] addr;
        logic [3:0]  be;
        logic        we;
        logic [31:0] wdata;
        int          len;
    } acc_t;

    typedef struct {
        logic [5:0]  op;
        logic [31:0] data;
    } ld_t;

    acc_t acc_q[$];
    ld_t  ld_q[$];
    int   err_q[$];

    int total = 0;
    int bad   = 0;
    int n_acc = 0;
    int n_pushed = 0;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s actual=%h required=%h", nm, act, exp);
        end
    endtask

    // Monitor
    logic prev_en = 1'b0;
    int   en_len  = 0;
    acc_t cur;

    always @(negedge clk) begin
        if (mem_en) begin
            if (!prev_en) begin
                n_acc++;
                en_len = 0;
                if (acc_q.size() == 0) begin
                    chk("acc_unexpected", 32'd1, 32'd0);
                    cur = '{addr: 32'h0, be: 4'h0, we: 1'b0, wdata: 32'h0, len: 0};
                end else begin
                    cur = acc_q.pop_front();
                end
            end
            en_len++;
            chk("mem_addr",  mem_addr,         cur.addr);
            chk("mem_be",    {28'h0, mem_be},  {28'h0, cur.be});
            chk("mem_we",    {31'h0, mem_we},  {31'h0, cur.we});
            chk("mem_wdata", mem_wdata,        cur.wdata);
        end else if (prev_en) begin
            chk("mem_en_len", 32'(en_len), 32'(cur.len));
        end
        prev_en = mem_en;

        if (ld_valid) begin
            if (ld_q.size() == 0) begin
                chk("ld_unexpected", 32'd1, 32'd0);
            end else begin
                ld_t e;
                e = ld_q.pop_front();
                chk("ld_opcode", {26'h0, ld_opcode}, {26'h0, e.op});
                chk("ld_data",   ld_data,            e.data);
            end
        end

        if (bus_err) begin
            if (err_q.size() == 0) chk("bus_err_unexpected", 32'd1, 32'd0);
            else void'(err_q.pop_front());
        end
    end

    // Issues one request starting at the current negedge. ack_k is the BUSY
    // cycle index carrying mem_ack (-1: never). Returns in the RESP cycle with
    // the request still held.
    task automatic run_access(input string nm, input logic [5:0] op,
                              input logic [31:0] addr, input logic [31:0] wdata,
                              input logic [31:0] rdata, input int ack_k,
                              input int exp_stall, input logic [3:0] exp_be,
                              input logic [31:0] exp_wdata, input logic [31:0] exp_ld);
        int st;
        int busy;
        bit done;
        acc_t a;
        ld_t  l;
        a.addr  = {addr[31:2], 2'b00};
        a.be    = exp_be;
        a.we    = op[3];
        a.wdata = exp_wdata;
        a.len   = (ack_k >= 0) ? ack_k + 1 : TO;
        acc_q.push_back(a);
        n_pushed++;
        if (!op[3] && ack_k >= 0) begin
            l.op   = op;
            l.data = exp_ld;
            ld_q.push_back(l);
        end
        if (ack_k < 0) err_q.push_back(1);

        req_valid = 1'b1;
        req_opcode = op;
        req_addr = addr;
        req_wdata = wdata;
        mem_ack = 1'b0;
        st = 0;
        busy = -1;
        done = 1'b0;
        for (int g = 0; g < 40 && !done; g++) begin
            #1;
            if (stall) begin
                st++;
                @(negedge clk);
                busy++;
                mem_ack   = (busy == ack_k);
                mem_rdata = (busy == ack_k) ? rdata : 32'h0;
            end else begin
                done = 1'b1;
            end
        end
        mem_ack = 1'b0;
        mem_rdata = 32'h0;
        if (!done) chk({nm, "_stall_timeout"}, 32'd1, 32'd0);
        chk({nm, "_stall_len"}, 32'(st), 32'(exp_stall));
    endtask

    initial begin
        int acc0;
        // Reset state
        #2;
        chk("rst_stall",    {31'h0, stall},    32'h0);
        chk("rst_mem_en",   {31'h0, mem_en},   32'h0);
        chk("rst_ld_valid", {31'h0, ld_valid}, 32'h0);
        chk("rst_bus_err",  {31'h0, bus_err},  32'h0);
        chk("rst_mem_addr", mem_addr,          32'h0);
        @(negedge clk);
        @(negedge clk);
        reset = 1'b0;
        @(negedge clk);

        // lb at byte 3, ack in third BUSY cycle
        run_access("lb", 6'b100000, 32'h0000_1003, 32'h0000_0055, 32'h80FF_1234,
                   2, 4, 4'b1000, 32'h0, 32'h0000_0080);
        @(negedge clk); req_valid = 1'b0;

        // sh upper half, immediate ack
        @(negedge clk);
        run_access("sh", 6'b101001, 32'h0000_2002, 32'hDEAD_BEEF, 32'h0,
                   0, 2, 4'b1100, 32'hBEEF_BEEF, 32'h0);
        @(negedge clk); req_valid = 1'b0;

        // lh low half, lbu byte 1
        @(negedge clk);
        run_access("lh", 6'b100001, 32'h0000_0000, 32'h0, 32'h80FF_1234,
                   1, 3, 4'b0011, 32'h0, 32'h0000_1234);
        @(negedge clk);
        run_access("lbu", 6'b100100, 32'h0000_1001, 32'h0, 32'h80FF_1234,
                   0, 2, 4'b0010, 32'h0, 32'h0000_0012);
        @(negedge clk); req_valid = 1'b0;

        // Misaligned lw and sh, and a non-memory opcode
        @(negedge clk);
        acc0 = n_acc;
        req_valid = 1'b1; req_opcode = 6'b100011; req_addr = 32'h0000_0006;
        #1;
        chk("lw_mis_misalign", {31'h0, misalign}, 32'h1);
        chk("lw_mis_stall",    {31'h0, stall},    32'h0);
        @(negedge clk);
        req_opcode = 6'b101001; req_addr = 32'h0000_0011;
        #1;
        chk("sh_mis_misalign", {31'h0, misalign}, 32'h1);
        @(negedge clk);
        req_opcode = 6'b000000; req_addr = 32'h0000_0000;
        #1;
        chk("rtype_stall",    {31'h0, stall},    32'h0);
        chk("rtype_misalign", {31'h0, misalign}, 32'h0);
        @(negedge clk);
        req_valid = 1'b0;
        @(negedge clk);
        chk("mis_no_access", 32'(n_acc - acc0), 32'd0);

        // lhu timeout
        run_access("lhu_to", 6'b100101, 32'h0000_3002, 32'h0, 32'h0,
                   -1, 1 + TO, 4'b1100, 32'h0, 32'h0);
        @(negedge clk); req_valid = 1'b0;
        @(negedge clk);

        // sw aborted by reset in its second BUSY cycle, then a late ack
        begin
            acc_t a;
            a.addr = 32'h0000_0040; a.be = 4'b1111; a.we = 1'b1;
            a.wdata = 32'hCAFE_F00D; a.len = 2;
            acc_q.push_back(a);
            n_pushed++;
        end
        req_valid = 1'b1; req_opcode = 6'b101011;
        req_addr = 32'h0000_0040; req_wdata = 32'hCAFE_F00D;
        #1;
        chk("sw_accept_stall", {31'h0, stall}, 32'h1);
        @(negedge clk);
        @(negedge clk);
        #2;
        reset = 1'b1;
        req_valid = 1'b0;
        #1;
        chk("rst_mid_stall",     {31'h0, stall},    32'h0);
        chk("rst_mid_mem_en",    {31'h0, mem_en},   32'h0);
        chk("rst_mid_mem_we",    {31'h0, mem_we},   32'h0);
        chk("rst_mid_mem_be",    {28'h0, mem_be},   32'h0);
        chk("rst_mid_mem_addr",  mem_addr,          32'h0);
        chk("rst_mid_mem_wdata", mem_wdata,         32'h0);
        chk("rst_mid_ld_data",   ld_data,           32'h0);
        @(negedge clk);
        reset = 1'b0;
        mem_ack = 1'b1;
        mem_rdata = 32'hFFFF_FFFF;
        @(negedge clk);
        mem_ack = 1'b0;
        mem_rdata = 32'h0;
        #1;
        chk("late_ack_stall",  {31'h0, stall},  32'h0);
        chk("late_ack_mem_en", {31'h0, mem_en}, 32'h0);
        @(negedge clk);
        run_access("lw_after_rst", 6'b100011, 32'h0000_0010, 32'h0, 32'h1234_5678,
                   0, 2, 4'b1111, 32'h0, 32'h1234_5678);
        @(negedge clk); req_valid = 1'b0;

        // Back-to-back lw then sb with req_valid held through RESP
        @(negedge clk);
        acc0 = n_acc;
        run_access("b2b_lw", 6'b100011, 32'h0000_0020, 32'h0, 32'hAABB_CCDD,
                   1, 3, 4'b1111, 32'h0, 32'hAABB_CCDD);
        @(negedge clk);
        run_access("b2b_sb", 6'b101000, 32'h0000_0025, 32'h0000_00A5, 32'h0,
                   0, 2, 4'b0010, 32'hA5A5_A5A5, 32'h0);
        @(negedge clk); req_valid = 1'b0;
        repeat (4) @(negedge clk);
        chk("b2b_access_count", 32'(n_acc - acc0), 32'd2);

        chk("acc_q_empty",  32'(acc_q.size()), 32'd0);
        chk("ld_q_empty",   32'(ld_q.size()),  32'd0);
        chk("err_q_empty",  32'(err_q.size()), 32'd0);
        chk("access_total", 32'(n_acc),        32'(n_pushed));

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL global_timeout actual=running required=finished");
        $fatal(1, "global timeout");
    end

endmodule
